// File: rtl/multicycle_control.sv
// multicycle_control: FSM sequencer for a multi-cycle RV32I datapath that
// shares one ALU and one unified instruction/data memory port.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// FETCH    | read instruction at PC, PC <= PC+4 and IR/OldPC latch on ready
// DECODE   | compute OldPC+imm (branch/jump target) and dispatch on opcode
// MEMADR   | effective address rs1+imm for lw/sw
// MEMREAD  | load request at ALUOut, wait for ready
// MEMWB    | write loaded data to rd
// MEMWRITE | store request at ALUOut, wait for ready
// EXECR    | register-register ALU operation
// EXECI    | register-immediate ALU operation
// ALUWB    | write ALUOut to rd (also OldPC+4 after jal)
// BRANCH   | compare rs1/rs2, redirect PC to target if taken
// JAL      | PC <= target, ALU computes OldPC+4 for the link register

module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       EQ,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUctrl,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [3:0] state_nxt;

  // funct3 decode shared by R- and I-type; sub only exists for R-type
  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_sel);
    logic [2:0] ctrl;
    case (f3)
      3'b000:  ctrl = sub_sel ? ALU_SUB : ALU_ADD;
      3'b010:  ctrl = ALU_SLT;
      3'b110:  ctrl = ALU_OR;
      3'b111:  ctrl = ALU_AND;
      default: ctrl = ALU_ADD;
    endcase
    return ctrl;
  endfunction

  // state register; reset wins over any pending transition or handshake
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:    state_nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = S_EXECR;
          OP_I:         state_nxt = S_EXECI;
          OP_BR:        state_nxt = S_BRANCH;
          OP_JAL:       state_nxt = S_JAL;
          default:      state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR:   state_nxt = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_nxt = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWRITE: state_nxt = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_nxt = S_ALUWB;
      S_EXECI:    state_nxt = S_ALUWB;
      S_ALUWB:    state_nxt = S_FETCH;
      S_BRANCH:   state_nxt = S_FETCH;
      S_JAL:      state_nxt = S_ALUWB;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // immediate format follows the opcode in every state
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BR:   ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // per-state datapath controls; enables are masked while reset is held
  always_comb begin
    mem_req   = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUctrl   = ALU_ADD;
    illegal   = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        illegal = !(op == OP_LW || op == OP_SW || op == OP_R ||
                    op == OP_I  || op == OP_BR || op == OP_JAL);
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUctrl = alu_decode(funct3, funct7b5);
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUctrl = alu_decode(funct3, 1'b0);
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUctrl = ALU_SUB;
        PCWrite = ((funct3 == 3'b000) && EQ) || ((funct3 == 3'b001) && !EQ);
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      mem_req  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: per-cycle stimulus and expected output
// vectors are queued per scenario, then replayed and compared cycle by cycle.

module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       EQ;
  logic       mem_ready;
  logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUctrl;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;

  multicycle_control dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .EQ(EQ), .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUctrl(ALUctrl), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  logic [21:0] obs;
  assign obs = {state, mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUctrl, illegal};

  typedef struct {
    logic        rst_v;
    logic        mr;
    logic        eq;
    logic [21:0] exp;
  } step_t;

  step_t scb[$];

  // field order: state req memwrite adrsrc irwrite pcwrite regwrite resultsrc srca srcb imm alu illegal
  function automatic logic [21:0] mk(input logic [3:0] st, input logic req, input logic mw,
                                     input logic adr, input logic irw, input logic pcw,
                                     input logic rw, input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sbv, input logic [1:0] im,
                                     input logic [2:0] alu, input logic ill);
    return {st, req, mw, adr, irw, pcw, rw, rs, sa, sbv, im, alu, ill};
  endfunction

  function automatic logic [21:0] e_fetch(input logic [1:0] im, input logic rdy);
    return mk(4'd0, 1, 0, 0, rdy, rdy, 0, 2'b10, 2'b00, 2'b10, im, 3'b000, 0);
  endfunction
  function automatic logic [21:0] e_decode(input logic [1:0] im, input logic ill);
    return mk(4'd1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, im, 3'b000, ill);
  endfunction
  function automatic logic [21:0] e_memadr(input logic [1:0] im);
    return mk(4'd2, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, 3'b000, 0);
  endfunction
  function automatic logic [21:0] e_memread(input logic [1:0] im);
    return mk(4'd3, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, 3'b000, 0);
  endfunction
  function automatic logic [21:0] e_memwb(input logic [1:0] im);
    return mk(4'd4, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, im, 3'b000, 0);
  endfunction
  function automatic logic [21:0] e_memwrite(input logic [1:0] im);
    return mk(4'd5, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, 3'b000, 0);
  endfunction
  function automatic logic [21:0] e_execr(input logic [2:0] alu);
    return mk(4'd6, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, alu, 0);
  endfunction
  function automatic logic [21:0] e_execi(input logic [2:0] alu);
    return mk(4'd7, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, alu, 0);
  endfunction
  function automatic logic [21:0] e_aluwb(input logic [1:0] im);
    return mk(4'd8, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, 3'b000, 0);
  endfunction
  function automatic logic [21:0] e_branch(input logic pcw);
    return mk(4'd9, 0, 0, 0, 0, pcw, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0);
  endfunction
  function automatic logic [21:0] e_jal();
    return mk(4'd10, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0);
  endfunction

  task automatic push(input logic r, input logic mr, input logic eq, input logic [21:0] e);
    step_t s;
    s.rst_v = r; s.mr = mr; s.eq = eq; s.exp = e;
    scb.push_back(s);
  endtask

  task automatic set_instr(input logic [31:0] instr);
    op = instr[6:0];
    funct3 = instr[14:12];
    funct7b5 = instr[30];
  endtask

  task automatic test_reset();
    int cyc = 0;
    set_instr(32'h002081B3);
    push(1, 1, 0, mk(4'd0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0));
    push(1, 0, 0, mk(4'd0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0));
    push(0, 0, 0, e_fetch(2'b00, 0));
    push(0, 1, 0, e_fetch(2'b00, 1));
    push(0, 0, 0, e_decode(2'b00, 0));
    push(0, 0, 0, e_execr(3'b000));
    push(0, 0, 0, e_aluwb(2'b00));
    while (scb.size() > 0) begin
      step_t s = scb.pop_front();
      rst = s.rst_v; mem_ready = s.mr; EQ = s.eq;
      #2;
      checks++;
      if (obs !== s.exp) begin
        failures++;
        $display("FAIL reset cyc=%0d got=%h expected=%h", cyc, obs, s.exp);
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_rtype();
    logic [31:0] instrs [6];
    logic [2:0]  alus [6];
    instrs[0] = 32'h002081B3; alus[0] = 3'b000;
    instrs[1] = 32'h402081B3; alus[1] = 3'b001;
    instrs[2] = 32'h0020A1B3; alus[2] = 3'b101;
    instrs[3] = 32'h0020E1B3; alus[3] = 3'b011;
    instrs[4] = 32'h0020F1B3; alus[4] = 3'b010;
    instrs[5] = 32'h0020C1B3; alus[5] = 3'b000;
    for (int i = 0; i < 6; i++) begin
      int cyc = 0;
      set_instr(instrs[i]);
      push(0, 1, 0, e_fetch(2'b00, 1));
      push(0, 0, 0, e_decode(2'b00, 0));
      push(0, 1, 0, e_execr(alus[i]));
      push(0, 0, 0, e_aluwb(2'b00));
      while (scb.size() > 0) begin
        step_t s = scb.pop_front();
        rst = s.rst_v; mem_ready = s.mr; EQ = s.eq;
        #2;
        checks++;
        if (obs !== s.exp) begin
          failures++;
          $display("FAIL rtype i=%0d cyc=%0d got=%h expected=%h", i, cyc, obs, s.exp);
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
  endtask

  task automatic test_itype();
    logic [31:0] instrs [5];
    logic [2:0]  alus [5];
    instrs[0] = 32'h40508093; alus[0] = 3'b000;
    instrs[1] = 32'h0050A093; alus[1] = 3'b101;
    instrs[2] = 32'h0050E093; alus[2] = 3'b011;
    instrs[3] = 32'h0050F093; alus[3] = 3'b010;
    instrs[4] = 32'h00509093; alus[4] = 3'b000;
    for (int i = 0; i < 5; i++) begin
      int cyc = 0;
      set_instr(instrs[i]);
      push(0, 1, 0, e_fetch(2'b00, 1));
      push(0, 1, 0, e_decode(2'b00, 0));
      push(0, 0, 0, e_execi(alus[i]));
      push(0, 1, 0, e_aluwb(2'b00));
      while (scb.size() > 0) begin
        step_t s = scb.pop_front();
        rst = s.rst_v; mem_ready = s.mr; EQ = s.eq;
        #2;
        checks++;
        if (obs !== s.exp) begin
          failures++;
          $display("FAIL itype i=%0d cyc=%0d got=%h expected=%h", i, cyc, obs, s.exp);
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
  endtask

  task automatic test_load_wait();
    int cyc = 0;
    set_instr(32'h00802283);
    push(0, 1, 0, e_fetch(2'b00, 1));
    push(0, 0, 0, e_decode(2'b00, 0));
    push(0, 0, 0, e_memadr(2'b00));
    push(0, 0, 0, e_memread(2'b00));
    push(0, 0, 0, e_memread(2'b00));
    push(0, 1, 0, e_memread(2'b00));
    push(0, 0, 0, e_memwb(2'b00));
    push(0, 0, 0, e_fetch(2'b00, 0));
    while (scb.size() > 0) begin
      step_t s = scb.pop_front();
      rst = s.rst_v; mem_ready = s.mr; EQ = s.eq;
      #2;
      checks++;
      if (obs !== s.exp) begin
        failures++;
        $display("FAIL load cyc=%0d got=%h expected=%h", cyc, obs, s.exp);
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_store_back_to_back();
    int cyc = 0;
    set_instr(32'h00512423);
    push(0, 1, 0, e_fetch(2'b01, 1));
    push(0, 0, 0, e_decode(2'b01, 0));
    push(0, 0, 0, e_memadr(2'b01));
    push(0, 0, 0, e_memwrite(2'b01));
    push(0, 1, 0, e_memwrite(2'b01));
    push(0, 1, 0, e_fetch(2'b01, 1));
    push(0, 1, 0, e_decode(2'b01, 0));
    push(0, 1, 0, e_memadr(2'b01));
    push(0, 1, 0, e_memwrite(2'b01));
    while (scb.size() > 0) begin
      step_t s = scb.pop_front();
      rst = s.rst_v; mem_ready = s.mr; EQ = s.eq;
      #2;
      checks++;
      if (obs !== s.exp) begin
        failures++;
        $display("FAIL store cyc=%0d got=%h expected=%h", cyc, obs, s.exp);
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3s [5];
    logic       eqs [5];
    logic       taken [5];
    f3s[0] = 3'b000; eqs[0] = 1; taken[0] = 1;
    f3s[1] = 3'b000; eqs[1] = 0; taken[1] = 0;
    f3s[2] = 3'b001; eqs[2] = 1; taken[2] = 0;
    f3s[3] = 3'b001; eqs[3] = 0; taken[3] = 1;
    f3s[4] = 3'b100; eqs[4] = 1; taken[4] = 0;
    for (int i = 0; i < 5; i++) begin
      int cyc = 0;
      op = 7'b1100011; funct3 = f3s[i]; funct7b5 = 1'b0;
      push(0, 1, !eqs[i], e_fetch(2'b10, 1));
      push(0, 1, !eqs[i], e_decode(2'b10, 0));
      push(0, 0, eqs[i], e_branch(taken[i]));
      while (scb.size() > 0) begin
        step_t s = scb.pop_front();
        rst = s.rst_v; mem_ready = s.mr; EQ = s.eq;
        #2;
        checks++;
        if (obs !== s.exp) begin
          failures++;
          $display("FAIL branch i=%0d cyc=%0d got=%h expected=%h", i, cyc, obs, s.exp);
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
  endtask

  task automatic test_jal();
    int cyc = 0;
    set_instr(32'h010000EF);
    push(0, 1, 0, e_fetch(2'b11, 1));
    push(0, 0, 0, e_decode(2'b11, 0));
    push(0, 0, 0, e_jal());
    push(0, 0, 0, e_aluwb(2'b11));
    while (scb.size() > 0) begin
      step_t s = scb.pop_front();
      rst = s.rst_v; mem_ready = s.mr; EQ = s.eq;
      #2;
      checks++;
      if (obs !== s.exp) begin
        failures++;
        $display("FAIL jal cyc=%0d got=%h expected=%h", cyc, obs, s.exp);
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_illegal();
    int cyc = 0;
    op = 7'h7F; funct3 = 3'b000; funct7b5 = 1'b0;
    push(0, 1, 0, e_fetch(2'b00, 1));
    push(0, 1, 0, e_decode(2'b00, 1));
    push(0, 0, 0, e_fetch(2'b00, 0));
    while (scb.size() > 0) begin
      step_t s = scb.pop_front();
      rst = s.rst_v; mem_ready = s.mr; EQ = s.eq;
      #2;
      checks++;
      if (obs !== s.exp) begin
        failures++;
        $display("FAIL illegal cyc=%0d got=%h expected=%h", cyc, obs, s.exp);
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    set_instr(32'h00802283);
    push(0, 1, 0, e_fetch(2'b00, 1));
    push(0, 0, 0, e_decode(2'b00, 0));
    push(0, 0, 0, e_memadr(2'b00));
    push(0, 0, 0, e_memread(2'b00));
    push(1, 1, 0, mk(4'd3, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
    push(0, 1, 0, e_fetch(2'b00, 1));
    push(0, 0, 0, e_decode(2'b00, 0));
    push(0, 0, 0, e_memadr(2'b00));
    push(0, 1, 0, e_memread(2'b00));
    push(0, 0, 0, e_memwb(2'b00));
    while (scb.size() > 0) begin
      step_t s = scb.pop_front();
      rst = s.rst_v; mem_ready = s.mr; EQ = s.eq;
      #2;
      checks++;
      if (obs !== s.exp) begin
        failures++;
        $display("FAIL reset_mid cyc=%0d got=%h expected=%h", cyc, obs, s.exp);
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    rst = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; EQ = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_rtype();
    test_itype();
    test_load_wait();
    test_store_back_to_back();
    test_branch();
    test_jal();
    test_illegal();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the RV32I core datapath. It lets one ALU and one unified instruction/data memory port be shared across the cycles of each instruction. A Moore/Mealy FSM walks each instruction through fetch, decode, execute, memory and writeback states. On every cycle it drives the datapath muxes, ALU control and write enables, stalling on a simple memory ready handshake. It replaces the combinational control unit when the core is built in multi-cycle form, and sits beside the register file, ALU and shared memory.

## Interface
- No parameters; opcodes and encodings are fixed RV32I.
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- op  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- EQ  in  1  ALU equality flag (ALUop1 == ALUop2)
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory access request (fetch, load or store)
- MemWrite  out  1  store strobe, valid only with mem_req
- AdrSrc  out  1  memory address: 0 = PC, 1 = Result
- IRWrite  out  1  latch instruction register and OldPC
- PCWrite  out  1  load PC from Result
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00 ALUOut, 01 memory data, 10 ALU result
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1 register
- ALUSrcB  out  2  00 rs2 register, 01 ImmOp, 10 constant 4
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J (decoded from op, all states)
- ALUctrl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode
- state  out  4  current state, for debug and bench

## Operation
- States, encoded 0–10: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL.
- FETCH
  - Outputs: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUctrl=add, ResultSrc=10.
  - IRWrite and PCWrite are high only when mem_ready=1.
  - Next state is DECODE if mem_ready=1, otherwise stay in FETCH.
- DECODE
  - Computes the branch/jump target: ALUSrcA=01, ALUSrcB=01, add.
  - Next state by op:
    - 0000011 (lw) or 0100011 (sw): MEMADR
    - 0110011: EXECR
    - 0010011: EXECI
    - 1100011: BRANCH
    - 1101111: JAL
    - anything else: illegal=1, next state FETCH, no writes.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next state MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00. Go to MEMWB when mem_ready=1.
- MEMWB: ResultSrc=01, RegWrite=1. Next state FETCH.
- MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1, ResultSrc=00. Go to FETCH when mem_ready=1.
- EXECR
  - ALUSrcA=10, ALUSrcB=00.
  - ALUctrl from funct3:
    - 000: sub if funct7b5=1, otherwise add
    - 010: slt
    - 110: or
    - 111: and
    - any other funct3: add
  - Next state ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01. ALUctrl as EXECR, except funct3=000 is always add. Next state ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next state FETCH.
- BRANCH
  - ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite = (funct3==000 & EQ) | (funct3==001 & !EQ). Any other funct3 is not taken.
  - Next state FETCH.
- JAL
  - ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1.
  - Next state ALUWB, which writes OldPC+4 into rd.
- Unlisted outputs are 0 in every state.

## Timing
- The state register updates on posedge clk. Outputs are combinational from state, plus mem_ready, EQ, op, funct3 and funct7b5.
- Reset
  - rst=1 at a clock edge puts state in FETCH; this takes priority over every transition, including mid-instruction and mid-handshake.
  - While rst=1, PCWrite, IRWrite, RegWrite, MemWrite, mem_req and illegal are forced to 0.
  - After reset, outputs equal FETCH with enables low: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUctrl=000, ResultSrc=10.
- Latency with mem_ready tied high, in cycles: lw 5, sw 4, R-type 4, I-type 4, branch 3, jal 4.
- Each wait cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. During a wait, outputs hold steady and no write enable besides MemWrite is asserted.
- mem_ready is ignored outside the memory states.
- Handshake: one access completes per cycle in which mem_req=1 and mem_ready=1. A new request may start in the very next cycle (MEMWRITE→FETCH back-to-back).

## Test plan
- Reset while in MEMREAD: state=0 on the next cycle, all enables 0 during rst. A fetch follows on the first cycle after rst falls.
- add x3,x1,x2 (0x002081B3), mem_ready=1: states FETCH, DECODE, EXECR, ALUWB. RegWrite=1 only in cycle 4, ALUctrl=000 in EXECR. sub (0x402081B3) gives ALUctrl=001.
- lw x5,8(x0) with mem_ready low for 2 cycles in MEMREAD: 7 cycles total. RegWrite=1 only in MEMWB, with ResultSrc=01.
- beq with EQ=1 then EQ=0: PCWrite=1 or 0 respectively in BRANCH, 3 cycles each. bne inverts this.
- jal x1,+16: PCWrite=1 in JAL, RegWrite=1 in the following ALUWB, 4 cycles.
- op=0x7F: illegal=1 for one cycle in DECODE, state returns to FETCH, RegWrite, MemWrite and PCWrite never asserted.
